// File: rtl/pixel_frame_buffer_pp_if.sv
// pixel_frame_buffer_pp_if: Avalon-MM slave bus between the host and the frame buffer
interface pixel_frame_buffer_pp_if;
  logic        avs_chipselect;
  logic        avs_write;
  logic        avs_read;
  logic [1:0]  avs_address;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  modport master (
    output avs_chipselect, avs_write, avs_read, avs_address, avs_writedata,
    input  avs_readdata
  );
  modport slave (
    input  avs_chipselect, avs_write, avs_read, avs_address, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pixel_frame_buffer_pp.sv
// pixel_frame_buffer_pp: ping-pong frame store; host fills one bank while the core reads the other
module pixel_frame_buffer_pp #(
  parameter int DEPTH = 784,
  parameter int PIX_W = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  pixel_frame_buffer_pp_if.slave avs,
  output logic                   frame_valid,
  output logic                   frame_bank,
  input  logic [IDX_W-1:0]       rd_addr,
  output logic [PIX_W-1:0]       rd_data,
  input  logic                   frame_done
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic fill_bank, pending;
  logic [IDX_W-1:0] wr_ptr, widx;
  logic [15:0] commit_cnt;
  logic [2:0] err, err_set;
  logic [PIX_W-1:0] ram [2][DEPTH];
  logic wr, pix_wr, str_wr, commit, clr, in_range, wrap, we;
  logic unused;
  assign unused = ^{avs.avs_read, avs.avs_writedata};
  assign frame_bank = ~fill_bank;
  always_comb begin
    wr = avs.avs_chipselect & avs.avs_write;
    pix_wr = wr & (avs.avs_address == 2'd0);
    commit = wr & (avs.avs_address == 2'd1) & avs.avs_writedata[0];
    clr = wr & (avs.avs_address == 2'd1) & avs.avs_writedata[1];
    str_wr = wr & (avs.avs_address == 2'd2);
    in_range = 32'(avs.avs_writedata[31:16]) < 32'(DEPTH);
    wrap = wr_ptr == IDX_W'(DEPTH - 1);
    we = ~pending & ((pix_wr & in_range) | str_wr);
    widx = pix_wr ? avs.avs_writedata[16 +: IDX_W] : wr_ptr;
    // err = {wrap, range, overrun}; a locked bank turns every host write into an overrun
    err_set = {str_wr & ~pending & wrap,
               pix_wr & ~pending & ~in_range,
               (pending & (pix_wr | str_wr)) | ((state == BUSY) & commit & pending)};
    avs.avs_readdata = avs.avs_address == 2'd1 ? {27'b0, err, pending, frame_valid} :
                       avs.avs_address == 2'd2 ? 32'(wr_ptr) :
                       avs.avs_address == 2'd3 ? {commit_cnt, 16'b0} : '0;
  end
  always_ff @(posedge clk)
    if (we) ram[fill_bank][widx] <= avs.avs_writedata[PIX_W-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      frame_valid <= 1'b0;
      fill_bank <= 1'b0;
      pending <= 1'b0;
      wr_ptr <= '0;
      commit_cnt <= '0;
      err <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= 32'(rd_addr) < 32'(DEPTH) ? ram[~fill_bank][rd_addr] : '0;
      err <= (err & ~{3{clr}}) | err_set;
      if (str_wr & ~pending) wr_ptr <= wrap ? '0 : wr_ptr + 1'b1;
      if (state == IDLE) begin
        if (commit | pending) begin
          fill_bank <= ~fill_bank;
          wr_ptr <= '0;
          pending <= 1'b0;
          commit_cnt <= commit_cnt + 1'b1;
          state <= BUSY;
          frame_valid <= 1'b1;
        end
      end else begin
        if (commit & ~pending) pending <= 1'b1;
        if (frame_done) begin
          state <= IDLE;
          frame_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pixel_frame_buffer_pp.sv
// tb_pixel_frame_buffer_pp: directed stimulus with a queue-based scoreboard and negedge monitor
module tb_pixel_frame_buffer_pp;
  localparam int DEPTH = 784;
  typedef struct {
    string name;
    int due;
    int kind;
    logic [31:0] exp;
  } chk_t;
  logic clk = 0, reset = 1, frame_valid, frame_bank, frame_done = 0;
  logic [9:0] rd_addr = '0;
  logic [7:0] rd_data;
  int cyc = 0, n_vec = 0, n_bad = 0;
  chk_t q[$];
  chk_t c;
  logic [31:0] act;
  pixel_frame_buffer_pp_if bus();
  pixel_frame_buffer_pp #(.DEPTH(DEPTH), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .avs(bus), .frame_valid(frame_valid), .frame_bank(frame_bank),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      c = q.pop_front();
      act = c.kind == 0 ? bus.avs_readdata : c.kind == 1 ? 32'(rd_data) :
            c.kind == 2 ? 32'(frame_valid) : 32'(frame_bank);
      n_vec++;
      if (act !== c.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, act, c.exp);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(string n, int d, int k, logic [31:0] e);
    chk_t t;
    t.name = n; t.due = d; t.kind = k; t.exp = e;
    q.push_back(t);
  endtask
  task automatic wr(logic [1:0] a, logic [31:0] d);
    bus.avs_chipselect = 1; bus.avs_write = 1; bus.avs_address = a; bus.avs_writedata = d;
    step();
    bus.avs_chipselect = 0; bus.avs_write = 0;
  endtask
  task automatic chk_reg(string n, logic [1:0] a, logic [31:0] e);
    bus.avs_chipselect = 1; bus.avs_read = 1; bus.avs_address = a;
    push(n, cyc, 0, e);
    step();
    bus.avs_chipselect = 0; bus.avs_read = 0;
  endtask
  task automatic chk_pix(string n, int a, logic [7:0] e);
    rd_addr = 10'(a);
    push(n, cyc + 1, 1, 32'(e));
    step();
  endtask
  task automatic chk_fv(string n, logic e);
    push(n, cyc, 2, 32'(e));
  endtask
  task automatic chk_fb(string n, logic e);
    push(n, cyc, 3, 32'(e));
  endtask
  task automatic done_pulse();
    frame_done = 1;
    step();
    frame_done = 0;
  endtask
  initial begin
    bus.avs_chipselect = 0; bus.avs_write = 0; bus.avs_read = 0;
    bus.avs_address = '0; bus.avs_writedata = '0;
    step(); step();
    push("rst_rd_data", cyc, 1, 0);
    chk_fv("rst_fv", 0);
    chk_fb("rst_bank", 1);
    chk_reg("rst_status", 1, 0);
    chk_reg("rst_wr_ptr", 2, 0);
    chk_reg("rst_cnt", 3, 0);
    reset = 0;
    step();
    // T1: fill bank 0 by stream, commit
    for (int i = 0; i < DEPTH; i++) wr(2, 32'(i));
    wr(1, 1);
    chk_fv("t1_fv", 1);
    chk_fb("t1_bank", 0);
    chk_pix("t1_pix5", 5, 8'h05);
    chk_pix("t1_pix783", 783, 8'h0F);
    chk_pix("t1_pix_oob", 784, 8'h00);
    chk_reg("t1_wr_ptr", 2, 0);
    chk_reg("t1_cnt", 3, 32'h0001_0000);
    chk_reg("t1_status", 1, 32'h11);
    // T2: range error and clear, then fill bank 1 by index
    wr(1, 2);
    chk_reg("t2_clr", 1, 32'h01);
    wr(0, 32'h0310_00AB);
    chk_reg("t2_range", 1, 32'h09);
    wr(1, 2);
    chk_reg("t2_clr2", 1, 32'h01);
    wr(0, 32'h000A_00CD);
    wr(0, 32'h030F_0077);
    wr(0, 32'h0000_0011);
    // T3: commit while busy -> pending, locked writes, release by frame_done
    wr(1, 1);
    chk_fv("t3_fv_hold", 1);
    chk_reg("t3_pending", 1, 32'h03);
    wr(0, 32'h000A_00EE);
    wr(2, 32'h0000_0099);
    chk_reg("t3_ovr", 1, 32'h07);
    chk_reg("t3_ptr_hold", 2, 0);
    done_pulse();
    chk_fv("t3_gap", 0);
    step();
    chk_fv("t3_fv_back", 1);
    chk_fb("t3_bank", 1);
    chk_pix("t3_pix10", 10, 8'hCD);
    chk_pix("t3_pix783", 783, 8'h77);
    chk_pix("t3_pix0", 0, 8'h11);
    chk_reg("t3_cnt", 3, 32'h0002_0000);
    chk_reg("t3_status", 1, 32'h05);
    // T4: double commit -> overrun, single increment
    wr(1, 2);
    wr(1, 1);
    wr(1, 1);
    chk_reg("t4_status", 1, 32'h07);
    chk_reg("t4_cnt_before", 3, 32'h0002_0000);
    done_pulse();
    step();
    chk_reg("t4_cnt_after", 3, 32'h0003_0000);
    done_pulse();
    step(); step();
    chk_fv("t4_idle", 0);
    chk_reg("t4_cnt_final", 3, 32'h0003_0000);
    chk_fb("t4_bank", 0);
    chk_pix("t4_pix5", 5, 8'h05);
    // T5: commit and frame_done in the same cycle
    wr(1, 2);
    wr(1, 1);
    chk_fv("t5_fv", 1);
    wr(0, 32'h000A_005A);
    frame_done = 1;
    wr(1, 1);
    frame_done = 0;
    chk_fv("t5_gap", 0);
    chk_reg("t5_gap_status", 1, 32'h02);
    chk_fv("t5_fv_back", 1);
    chk_reg("t5_status", 1, 32'h01);
    chk_fb("t5_bank", 0);
    chk_pix("t5_pix10", 10, 8'h5A);
    chk_reg("t5_cnt", 3, 32'h0005_0000);
    // T6: stream wrap, then reset while busy
    for (int i = 0; i <= DEPTH; i++) wr(2, 32'(i ^ 8'hA5));
    chk_reg("t6_wr_ptr", 2, 1);
    chk_reg("t6_status", 1, 32'h11);
    done_pulse();
    wr(1, 1);
    chk_pix("t6_pix0", 0, 8'hB5);
    chk_pix("t6_pix1", 1, 8'hA4);
    chk_pix("t6_pix783", 783, 8'hAA);
    chk_reg("t6_cnt", 3, 32'h0006_0000);
    reset = 1;
    step();
    reset = 0;
    chk_fv("t6_rst_fv", 0);
    chk_fb("t6_rst_bank", 1);
    push("t6_rst_rd_data", cyc, 1, 0);
    chk_reg("t6_rst_status", 1, 0);
    chk_reg("t6_rst_cnt", 3, 0);
    chk_reg("t6_rst_ptr", 2, 0);
    repeat (3) step();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: %0d checks pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
